// File: rtl/bus_tracer.sv
// -----------------------------------------------------------------------------
// bus_tracer
//
// Passive 6502-style bus tracer. Each CPU bus cycle (marked by a falling edge
// of PHI2) is sampled into a small trace FIFO as {SYNC, RW, A, D}. A debugger
// reads the FIFO head first-word-fall-through. A single-step helper produces a
// fixed-length, registered, active-low NMI pulse on request.
//
// Ports
//   CLK25MHZ     in   system clock, all logic on its rising edge
//   rst_n        in   asynchronous active-low reset
//   PHI2         in   CPU phase-2 clock (asynchronous)
//   RW           in   CPU read/write, 1 = read (asynchronous)
//   SYNC         in   CPU opcode-fetch flag (asynchronous)
//   A            in   CPU address bus [ADDR_W] (asynchronous)
//   D            in   CPU data bus [DATA_W] (asynchronous)
//   arm          in   level, 1 enables capture of bus cycles
//   overwrite    in   full-FIFO policy: 0 drop newest, 1 replace oldest
//   rd_en        in   pop the head entry
//   clr          in   flush FIFO and clear overflow (beats everything else)
//   step         in   single-step request pulse
//   rd_data      out  head entry {SYNC,RW,A,D}, valid while empty = 0
//   empty        out  FIFO holds no entries
//   full         out  FIFO holds DEPTH entries
//   count        out  number of stored entries [log2(DEPTH)+1]
//   overflow     out  sticky: a bus cycle was lost or overwritten
//   NMIn         out  active-low NMI pulse to the CPU, registered
//   o_nmi_state  out  debug view of the NMI FSM state (0 IDLE, 1 PULSE)
//
// Read handshake: rd_data is valid whenever empty = 0. A pop happens on a
// clock edge where rd_en = 1 and empty = 0; the next entry (if any) appears
// on rd_data after that edge. rd_en while empty is ignored.
// -----------------------------------------------------------------------------
module bus_tracer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int NMI_W  = 128
) (
    input  logic                         CLK25MHZ,
    input  logic                         rst_n,
    input  logic                         PHI2,
    input  logic                         RW,
    input  logic                         SYNC,
    input  logic [ADDR_W-1:0]            A,
    input  logic [DATA_W-1:0]            D,
    input  logic                         arm,
    input  logic                         overwrite,
    input  logic                         rd_en,
    input  logic                         clr,
    input  logic                         step,
    output logic [ADDR_W+DATA_W+1:0]     rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         NMIn,
    output logic                         o_nmi_state
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W + 2;
    localparam int NCNT_W  = 16;

    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [NCNT_W-1:0] NMI_ONE  = NCNT_W'(1);
    localparam logic [NCNT_W-1:0] NMI_LOAD = NCNT_W'(NMI_W - 1);

    localparam logic [0:0] NMI_IDLE  = 1'b0;
    localparam logic [0:0] NMI_PULSE = 1'b1;

    // -------------------------------------------------------------------------
    // Input synchronizers: two flops on every CPU-side signal.
    // The bus fields are packed in the same order as a FIFO entry.
    // -------------------------------------------------------------------------
    logic               r_phi2_meta;
    logic               r_phi2_sync;
    logic [ENTRY_W-1:0] r_bus_meta;
    logic [ENTRY_W-1:0] r_bus_sync;
    logic [1:0]         r_phi2_hist;

    always_ff @(posedge CLK25MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_phi2_meta <= 1'b0;
            r_phi2_sync <= 1'b0;
            r_bus_meta  <= '0;
            r_bus_sync  <= '0;
            r_phi2_hist <= 2'b00;
        end else begin
            r_phi2_meta <= PHI2;
            r_phi2_sync <= r_phi2_meta;
            r_bus_meta  <= {SYNC, RW, A, D};
            r_bus_sync  <= r_bus_meta;
            // hist[1] is the older sample, so 2'b10 is a falling edge.
            r_phi2_hist <= {r_phi2_hist[0], r_phi2_sync};
        end
    end

    // -------------------------------------------------------------------------
    // Trace FIFO
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic w_capture;
    logic w_wr_req;
    logic w_rd_ok;
    logic w_empty;
    logic w_full;
    logic w_mem_we;
    logic w_head_adv;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_capture = (r_phi2_hist == 2'b10);
    assign w_wr_req  = w_capture & arm;
    assign w_rd_ok   = rd_en & ~w_empty;

    // A write lands in memory when there is room, when a pop frees the head
    // slot in the same clock, or when overwrite mode recycles the oldest slot.
    assign w_mem_we   = ~clr & w_wr_req & (w_rd_ok | ~w_full | overwrite);
    // Head moves on a pop, or when an overwrite replaces the oldest entry.
    // When full with both a pop and a write, it still moves only once.
    assign w_head_adv = ~clr & (w_rd_ok | (w_mem_we & w_full));

    always_ff @(posedge CLK25MHZ) begin
        if (w_mem_we) begin
            r_mem[r_tail] <= r_bus_sync;
        end
    end

    always_ff @(posedge CLK25MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_mem_we) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_head_adv) begin
                r_head <= r_head + PTR_ONE;
            end
            if (w_mem_we && !w_head_adv) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_mem_we && w_rd_ok) begin
                r_count <= r_count - CNT_ONE;
            end
            // Lost (dropped) or overwritten cycle; a pop alongside the write
            // makes room, so nothing is lost in that case.
            if (w_wr_req && w_full && !w_rd_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_data  = r_mem[r_head];
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

    // -------------------------------------------------------------------------
    // NMI single-step pulse generator
    // IDLE  -> PULSE on step, counter loaded with NMI_W-1
    // PULSE -> IDLE  when the counter has counted down to 0
    // NMIn is its own flop, updated on the same edges as the state, so it is
    // low exactly while in PULSE: NMI_W clocks starting the clock after step.
    // -------------------------------------------------------------------------
    logic [0:0]        r_nmi_state;
    logic [NCNT_W-1:0] r_nmi_cnt;
    logic              r_nmin;

    always_ff @(posedge CLK25MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_nmi_state <= NMI_IDLE;
            r_nmi_cnt   <= '0;
            r_nmin      <= 1'b1;
        end else if (r_nmi_state == NMI_IDLE) begin
            if (step) begin
                r_nmi_state <= NMI_PULSE;
                r_nmi_cnt   <= NMI_LOAD;
                r_nmin      <= 1'b0;
            end
        end else begin
            // step is ignored here, so a pulse is never extended
            if (r_nmi_cnt == '0) begin
                r_nmi_state <= NMI_IDLE;
                r_nmin      <= 1'b1;
            end else begin
                r_nmi_cnt <= r_nmi_cnt - NMI_ONE;
            end
        end
    end

    assign NMIn        = r_nmin;
    assign o_nmi_state = r_nmi_state;

endmodule

// File: doc/bus_tracer.md
BUS_TRACER -- requirements
Module: bus_tracer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning CPU address bus width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning CPU data bus width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning trace FIFO entries; legal values are powers of 2 from 2 to 256.
REQ-004 SHALL have parameter NMI_W, default 128, meaning NMI low-pulse length in clocks; legal range is 1 to 65535.
REQ-005 SHALL have port CLK25MHZ  input  1  system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port PHI2  input  1  CPU phase-2 clock, asynchronous to CLK25MHZ.
REQ-008 SHALL have port RW  input  1  CPU read/write (1=read), asynchronous.
REQ-009 SHALL have port SYNC  input  1  CPU opcode-fetch flag, asynchronous.
REQ-010 SHALL have port A  input  ADDR_W  CPU address, asynchronous.
REQ-011 SHALL have port D  input  DATA_W  CPU data, asynchronous.
REQ-012 SHALL have port arm  input  1  level; 1 enables capture.
REQ-013 SHALL have port overwrite  input  1  mode; 0 drops new cycles when full, 1 replaces the oldest entry.
REQ-014 SHALL have port rd_en  input  1  pop head entry.
REQ-015 SHALL have port clr  input  1  flush the FIFO and clear overflow.
REQ-016 SHALL have port step  input  1  single-step request pulse.
REQ-017 SHALL have port rd_data  output  ADDR_W+DATA_W+2  head entry {SYNC,RW,A,D}, first-word-fall-through.
REQ-018 SHALL have port empty  output  1  FIFO empty.
REQ-019 SHALL have port full  output  1  FIFO full.
REQ-020 SHALL have port count  output  log2(DEPTH)+1  number of stored entries.
REQ-021 SHALL have port overflow  output  1  sticky flag; a cycle was lost or overwritten.
REQ-022 SHALL have port NMIn  output  1  active-low NMI pulse to the CPU.

Function
REQ-023 SHALL pass PHI2, RW, SYNC, A and D each through a 2-flop synchronizer; these flops reset to 0.
REQ-024 SHALL keep a 2-bit history of synchronized PHI2 and SHALL detect a capture event when the history is 2'b10 (PHI2 falling edge).
REQ-025 SHALL, on a capture event with arm=1, write the synchronized {SYNC,RW,A,D} at the tail pointer; empty and count SHALL update on the next clock (write latency 1).
REQ-026 SHALL ignore capture events while arm=0; arm SHALL NOT affect reads.
REQ-027 SHALL, on a capture event with full=1 and overwrite=0, drop the entry and set overflow; the FIFO contents SHALL be unchanged.
REQ-028 SHALL, on a capture event with full=1 and overwrite=1, advance head and tail together, set overflow, and leave count equal to DEPTH.
REQ-029 SHALL, on rd_en with empty=0, advance the head pointer; rd_en with empty=1 SHALL be ignored and SHALL NOT underflow.
REQ-030 SHALL, on simultaneous write and rd_en with the FIFO non-empty, perform both operations and leave count unchanged; this applies even when full, regardless of overwrite, and SHALL NOT set overflow.
REQ-031 SHALL, on simultaneous write and rd_en with the FIFO empty, perform the write only.
REQ-032 SHALL wrap head and tail pointers modulo DEPTH.
REQ-033 SHALL give clr priority over all FIFO activity: pointers and count go to 0, overflow goes to 0, and a coincident capture is discarded.
REQ-034 SHALL keep overflow set until clr or reset.
REQ-035 SHALL implement the NMI generator as a two-state FSM, IDLE and PULSE.
REQ-036 SHALL move the NMI FSM from IDLE to PULSE on step, loading a down-counter with NMI_W-1.
REQ-037 SHALL, in PULSE, decrement the counter each clock and return to IDLE when the counter reaches 0.
REQ-038 SHALL drive NMIn=0 exactly while the NMI FSM is in PULSE, giving exactly NMI_W clocks low starting the clock after step.
REQ-039 SHALL ignore step while in PULSE; the pulse is not extended.
REQ-040 SHALL register NMIn so that it is glitch-free.

Reset
REQ-041 SHALL, while rst_n=0, force empty=1, full=0, count=0, overflow=0, NMIn=1, the NMI FSM to IDLE, pointers to 0 and the PHI2 history to 0.
REQ-042 SHALL, on reset asserted mid-pulse, return NMIn to 1 immediately; reset mid-capture SHALL leave no partial entry.
REQ-043 SHALL ignore the first PHI2 edge after reset if the synchronized history is not yet 2'b10.

Verification
REQ-044 Bench SHALL, with DEPTH=16 and arm=1, drive 3 PHI2 cycles with A=FF00/FF01/FF02, D=11/22/33, RW=1, then check rd_data order FF00/11, FF01/22, FF02/33, with count decrementing 3 to 0 and empty=1 at the end.
REQ-045 Bench SHALL, with overwrite=0, drive 20 cycles with A=0..19, then check count=16, full=1, overflow=1 and a head entry of A=0.
REQ-046 Bench SHALL, with overwrite=1, drive 20 cycles with A=0..19, then check count=16, overflow=1, a head entry of A=4 and a last entry of A=19.
REQ-047 Bench SHALL, with the FIFO full, assert rd_en on the capture clock, then check count=16 and overflow=0; it SHALL then pulse clr alongside a capture and check count=0 and empty=1.
REQ-048 Bench SHALL, with NMI_W=128, pulse step, pulse step again 50 clocks later, then assert rst_n=0 during a third pulse, and check NMIn low for exactly 128 clocks, no extension, and NMIn=1 immediately on reset.
